// File: rtl/t2c_maze_world_model.sv
// Maze environment model: 9x9 wall map plus bot pose; executes explorer moves and returns wall sensors.
// Optional feature: define MAZE_VISIT_TRACK_EN to keep a visited-cell bitmap and drive visited_cnt.
module t2c_maze_world_model #(
  parameter int ROWS       = 9,
  parameter int COLS       = 9,
  parameter int START_ROW  = 4,
  parameter int START_COL  = 0,
  parameter int START_HEAD = 1,
  parameter int EXIT_ROW   = 4,
  parameter int EXIT_COL   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [6:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        start,
  input  logic [2:0]  move,
  output logic        left,
  output logic        mid,
  output logic        right,
  output logic [3:0]  pos_row,
  output logic [3:0]  pos_col,
  output logic [1:0]  heading,
  output logic        at_exit,
  output logic        collision,
  output logic        illegal,
  output logic [15:0] step_cnt,
  output logic [7:0]  deadend_cnt,
  output logic [6:0]  visited_cnt
);

  localparam int CELLS = ROWS * COLS;
  localparam logic [6:0] START_IDX = 7'(START_ROW * COLS + START_COL);

  localparam logic [2:0] MV_STOP  = 3'd0;
  localparam logic [2:0] MV_FWD   = 3'd1;
  localparam logic [2:0] MV_LEFT  = 3'd2;
  localparam logic [2:0] MV_RIGHT = 3'd3;
  localparam logic [2:0] MV_UTURN = 3'd4;

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  map_mem [CELLS];
  logic [3:0]  cur_mask, nxt_mask, start_mask;
  logic [6:0]  cur_idx, nxt_idx;
  logic [3:0]  row_n, col_n;
  logic [1:0]  head_n;
  logic        at_edge, blocked, moved, step_inc, bad_move, exit_hit;

  function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return 7'(int'(r) * COLS + int'(c));
  endfunction

  // Returns {left, mid, right} for a cell mask {W,S,E,N} seen from heading h.
  function automatic logic [2:0] sense(input logic [3:0] mask, input logic [1:0] h);
    return {mask[2'(h + 2'd3)], mask[h], mask[2'(h + 2'd1)]};
  endfunction

  assign cur_idx  = cell_idx(pos_row, pos_col);
  assign cur_mask = map_mem[cur_idx];
  assign nxt_idx  = cell_idx(row_n, col_n);
  assign nxt_mask = map_mem[nxt_idx];
  // A write coinciding with start must already be visible to the start sensors.
  assign start_mask = (wr_en && wr_addr == START_IDX) ? wr_data : map_mem[START_IDX];

  always_comb begin
    unique case (heading)
      2'd0:    at_edge = (pos_row == 4'd0);
      2'd1:    at_edge = (pos_col == 4'(COLS - 1));
      2'd2:    at_edge = (pos_row == 4'(ROWS - 1));
      default: at_edge = (pos_col == 4'd0);
    endcase
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    row_n    = pos_row;
    col_n    = pos_col;
    head_n   = heading;
    step_inc = 1'b0;
    blocked  = 1'b0;
    moved    = 1'b0;
    bad_move = 1'b0;
    if (state == RUN) begin
      unique case (move)
        MV_STOP: ;
        MV_FWD: begin
          step_inc = 1'b1;
          if (cur_mask[heading] || at_edge) begin
            blocked = 1'b1;
          end else begin
            moved = 1'b1;
            unique case (heading)
              2'd0:    row_n = pos_row - 4'd1;
              2'd1:    col_n = pos_col + 4'd1;
              2'd2:    row_n = pos_row + 4'd1;
              default: col_n = pos_col - 4'd1;
            endcase
          end
        end
        MV_LEFT: begin
          step_inc = 1'b1;
          head_n   = heading + 2'd3;
        end
        MV_RIGHT: begin
          step_inc = 1'b1;
          head_n   = heading + 2'd1;
        end
        MV_UTURN: begin
          step_inc = 1'b1;
          head_n   = heading + 2'd2;
        end
        default: bad_move = 1'b1;
      endcase
    end
  end

  assign exit_hit = moved && (row_n == 4'(EXIT_ROW)) && (col_n == 4'(EXIT_COL));

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (start) state_nxt = RUN;
      RUN:     if (exit_hit) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // NOTE: the wall map has no reset on purpose; it must survive rst so a run can restart without reloading.
  always_ff @(posedge clk) begin
    if (state == LOAD && wr_en && wr_addr < 7'(CELLS))
      map_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_row                <= 4'(START_ROW);
      pos_col                <= 4'(START_COL);
      heading                <= 2'(START_HEAD);
      {left, mid, right}     <= 3'b000;
      at_exit                <= 1'b0;
      collision              <= 1'b0;
      illegal                <= 1'b0;
      step_cnt               <= '0;
      deadend_cnt            <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (start) {left, mid, right} <= sense(start_mask, 2'(START_HEAD));
        end
        RUN: begin
          pos_row            <= row_n;
          pos_col            <= col_n;
          heading            <= head_n;
          {left, mid, right} <= sense(nxt_mask, head_n);
          if (step_inc && step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
          if (blocked)  collision <= 1'b1;
          if (bad_move) illegal   <= 1'b1;
          if (moved && $countones(nxt_mask) == 3 && deadend_cnt != 8'hFF)
            deadend_cnt <= deadend_cnt + 8'd1;
          if (exit_hit) at_exit <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MAZE_VISIT_TRACK_EN
  logic [CELLS-1:0] visited;

  always_ff @(posedge clk) begin
    if (rst) begin
      visited     <= '0;
      visited_cnt <= '0;
    end else if (state == LOAD && start) begin
      visited            <= '0;
      visited[START_IDX] <= 1'b1;
      visited_cnt        <= 7'd1;
    end else if (moved && !visited[nxt_idx]) begin
      visited[nxt_idx] <= 1'b1;
      visited_cnt      <= visited_cnt + 7'd1;
    end
  end
`else
  assign visited_cnt = 7'd0;
`endif

endmodule

// File: tb/tb_t2c_maze_world_model.sv
// Scoreboard bench for t2c_maze_world_model: driver queues hand-computed expectations, monitor compares.
module tb_t2c_maze_world_model;

  localparam logic [2:0] STOP = 3'd0, FWD = 3'd1, LEFT = 3'd2, RIGHT = 3'd3, UTURN = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic        start = 1'b0;
  logic [2:0]  move = STOP;
  logic        left, mid, right, at_exit, collision, illegal;
  logic [3:0]  pos_row, pos_col;
  logic [1:0]  heading;
  logic [15:0] step_cnt;
  logic [7:0]  deadend_cnt;
  logic [6:0]  visited_cnt;

  t2c_maze_world_model dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .move(move), .left(left), .mid(mid), .right(right),
    .pos_row(pos_row), .pos_col(pos_col), .heading(heading), .at_exit(at_exit),
    .collision(collision), .illegal(illegal), .step_cnt(step_cnt),
    .deadend_cnt(deadend_cnt), .visited_cnt(visited_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  r, c;
    logic [1:0]  h;
    logic [2:0]  lmr;
    logic        ex, col, ill;
    logic [15:0] st;
    logic [7:0]  de;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input string n, input int r, input int c, input int h,
                              input logic [2:0] lmr, input logic ex, input logic col,
                              input logic ill, input int st, input int de);
    exp_t e;
    e.name = n; e.r = 4'(r); e.c = 4'(c); e.h = 2'(h); e.lmr = lmr;
    e.ex = ex; e.col = col; e.ill = ill; e.st = 16'(st); e.de = 8'(de);
    return e;
  endfunction

  task automatic drive(input logic r, input logic we, input logic [6:0] wa,
                       input logic [3:0] wd, input logic st, input logic [2:0] mv,
                       input exp_t e);
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; start = st; move = mv;
    @(posedge clk);
    q.push_back(e);
  endtask

  // Monitor: every output snapshot after a driven edge is compared against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (pos_row !== e.r || pos_col !== e.c || heading !== e.h ||
          {left, mid, right} !== e.lmr || at_exit !== e.ex || collision !== e.col ||
          illegal !== e.ill || step_cnt !== e.st || deadend_cnt !== e.de ||
          visited_cnt !== 7'd0) begin
        n_fail++;
        $display("FAIL %s: got pose=(%0d,%0d,%0d) lmr=%b exit=%b col=%b ill=%b step=%0d dead=%0d vis=%0d, expected pose=(%0d,%0d,%0d) lmr=%b exit=%b col=%b ill=%b step=%0d dead=%0d vis=0",
                 e.name, pos_row, pos_col, heading, {left, mid, right}, at_exit, collision,
                 illegal, step_cnt, deadend_cnt, visited_cnt, e.r, e.c, e.h, e.lmr, e.ex,
                 e.col, e.ill, e.st, e.de);
      end
    end
  end

  initial begin
    logic [6:0] waddr [12];
    logic [3:0] wdata [12];
    waddr = '{7'd37, 7'd38, 7'd29, 7'd20, 7'd21, 7'd39, 7'd40, 7'd41, 7'd42, 7'd43, 7'd44, 7'd100};
    wdata = '{4'b0101, 4'b0100, 4'b1010, 4'b1001, 4'b0111, 4'b0101, 4'b0101, 4'b0101,
              4'b0101, 4'b0101, 4'b0101, 4'b1111};

    // Phase 1: dead-end neighbour, wall/edge collisions, rotations and an illegal code.
    drive(1, 0, 0, 0, 0, STOP, mk("reset", 4, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    drive(0, 1, 7'd37, 4'b0111, 0, FWD, mk("load_ignores_move", 4, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    drive(0, 1, 7'd36, 4'b0101, 1, STOP, mk("start_with_write", 4, 0, 1, 3'b101, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, FWD,   mk("fwd_deadend", 4, 1, 1, 3'b111, 0, 0, 0, 1, 1));
    drive(0, 0, 0, 0, 0, FWD,   mk("fwd_wall", 4, 1, 1, 3'b111, 0, 1, 0, 2, 1));
    drive(0, 0, 0, 0, 0, UTURN, mk("uturn_w", 4, 1, 3, 3'b101, 0, 1, 0, 3, 1));
    drive(0, 0, 0, 0, 0, FWD,   mk("fwd_back", 4, 0, 3, 3'b101, 0, 1, 0, 4, 1));
    drive(0, 0, 0, 0, 0, FWD,   mk("fwd_edge", 4, 0, 3, 3'b101, 0, 1, 0, 5, 1));
    drive(0, 0, 0, 0, 0, STOP,  mk("stop_hold", 4, 0, 3, 3'b101, 0, 1, 0, 5, 1));
    drive(0, 0, 0, 0, 0, UTURN, mk("uturn_e", 4, 0, 1, 3'b101, 0, 1, 0, 6, 1));
    drive(0, 0, 0, 0, 0, LEFT,  mk("left_n", 4, 0, 0, 3'b010, 0, 1, 0, 7, 1));
    drive(0, 0, 0, 0, 0, RIGHT, mk("right_e", 4, 0, 1, 3'b101, 0, 1, 0, 8, 1));
    drive(0, 0, 0, 0, 0, UTURN, mk("uturn_w2", 4, 0, 3, 3'b101, 0, 1, 0, 9, 1));
    drive(0, 0, 0, 0, 0, 3'd6,  mk("illegal6", 4, 0, 3, 3'b101, 0, 1, 1, 9, 1));

    // Phase 2: reset mid-run, reload a corridor map, walk to (2,3), reset there.
    drive(1, 0, 0, 0, 0, STOP, mk("reset_run", 4, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 12; i++)
      drive(0, 1, waddr[i], wdata[i], 0, FWD, mk("load_map", 4, 0, 1, 3'b000, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 1, STOP, mk("start2", 4, 0, 1, 3'b101, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, FWD,   mk("p_41", 4, 1, 1, 3'b101, 0, 0, 0, 1, 0));
    drive(0, 0, 0, 0, 0, FWD,   mk("p_42", 4, 2, 1, 3'b001, 0, 0, 0, 2, 0));
    drive(0, 0, 0, 0, 0, LEFT,  mk("p_42n", 4, 2, 0, 3'b000, 0, 0, 0, 3, 0));
    drive(0, 0, 0, 0, 0, FWD,   mk("p_32", 3, 2, 0, 3'b101, 0, 0, 0, 4, 0));
    drive(0, 0, 0, 0, 0, FWD,   mk("p_22", 2, 2, 0, 3'b110, 0, 0, 0, 5, 0));
    drive(0, 0, 0, 0, 0, RIGHT, mk("p_22e", 2, 2, 1, 3'b100, 0, 0, 0, 6, 0));
    drive(0, 0, 0, 0, 0, FWD,   mk("p_23", 2, 3, 1, 3'b111, 0, 0, 0, 7, 1));
    drive(1, 0, 0, 0, 0, FWD,   mk("reset_at_23", 4, 0, 1, 3'b000, 0, 0, 0, 0, 0));

    // Phase 3: restart without reloading, run east to the exit, then confirm DONE holds.
    drive(0, 0, 0, 0, 1, STOP, mk("start_noreload", 4, 0, 1, 3'b101, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 8; c++)
      drive(0, 0, 0, 0, 0, FWD, mk("east_run", 4, c, 1, (c == 2) ? 3'b001 : 3'b101,
                                   (c == 8), 0, 0, c, 0));
    drive(0, 0, 0, 0, 0, FWD,  mk("done_fwd", 4, 8, 1, 3'b101, 1, 0, 0, 8, 0));
    drive(0, 0, 0, 0, 0, LEFT, mk("done_left", 4, 8, 1, 3'b101, 1, 0, 0, 8, 0));
    drive(0, 1, 7'd44, 4'b1111, 0, 3'd7, mk("done_illegal", 4, 8, 1, 3'b101, 1, 0, 0, 8, 0));

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
